loopback_mcnt_arbiter: RTL and testbench

Round-robin arbiter that shares the single user-side readout register of a loopback mux mcnt monitor between several loopback channels. Each channel pulses a valid strobe with its current 32-bit mcnt; the block buffers one value per channel and grants channels in turn. It drives the winner's value onto the register's `user_data_in`, then holds it long enough for a PPC/OPB read. The block sits in the `user_clk` domain, directly in front of the simulink-to-PPC register.

---
 rtl/loopback_mcnt_pkg.sv | 8 +
 rtl/loopback_mcnt_arbiter_rr_pick.sv | 22 ++
 rtl/loopback_mcnt_arbiter.sv | 90 +++++++++
 tb/tb_loopback_mcnt_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopback_mcnt_pkg.sv
// loopback_mcnt_pkg: shared FSM state, mcnt width and channel-index width helper.
package loopback_mcnt_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
    localparam int MCNT_W = 32;
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/loopback_mcnt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set-bit finder starting at rr_ptr.
module rr_pick import loopback_mcnt_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int CHAN_W = 2
) (
    input  logic [N_REQ-1:0]  pending,
    input  logic [CHAN_W-1:0] rr_ptr,
    output logic [CHAN_W-1:0] winner,
    output logic              any_set
);
    int s;
    always_comb begin
        winner = '0;
        any_set = |pending;
        s = 0;
        // Scan from the farthest offset down so the nearest set bit wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = (int'(rr_ptr) + k) % N_REQ;
            if (pending[s[CHAN_W-1:0]]) winner = s[CHAN_W-1:0];
        end
    end
endmodule

// File: rtl/loopback_mcnt_arbiter.sv
// loopback_mcnt_arbiter: round-robin share of one mcnt readout register between loopback channels.
// Define LOOPBACK_MCNT_TAG_EN to put the winner index in the top bits of user_data_out.
module loopback_mcnt_arbiter import loopback_mcnt_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int HOLD_CYCLES = 256,
    localparam int CHAN_W = chan_w(N_REQ)
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [MCNT_W*N_REQ-1:0] req_mcnt,
    output logic [MCNT_W-1:0]       user_data_out,
    output logic [CHAN_W-1:0]       out_chan,
    output logic                    out_update,
    output logic [N_REQ-1:0]        pending,
    output logic [N_REQ-1:0]        overrun,
    output logic                    busy
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    state_t state;
    logic [CHAN_W-1:0] rr_ptr, winner;
    logic [CNT_W-1:0] cnt;
    logic [MCNT_W-1:0] shadow [N_REQ];
    logic [MCNT_W-1:0] win_val;
    logic [N_REQ-1:0] grant_mask;
    logic any_set, grant;

    rr_pick #(.N_REQ(N_REQ), .CHAN_W(CHAN_W)) u_pick (
        .pending(pending),
        .rr_ptr(rr_ptr),
        .winner(winner),
        .any_set(any_set)
    );

    assign grant = (state == IDLE) && any_set;
    assign grant_mask = grant ? N_REQ'(1) << winner : '0;
`ifdef LOOPBACK_MCNT_TAG_EN
    assign win_val = {winner, shadow[winner][MCNT_W-1-CHAN_W:0]};
`else
    assign win_val = shadow[winner];
`endif

    // A capture in the grant cycle re-arms pending and is not an overrun.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            for (int i = 0; i < N_REQ; i++) shadow[i] <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (req_valid[i]) shadow[i] <= req_mcnt[MCNT_W*i +: MCNT_W];
            pending <= (pending & ~grant_mask) | req_valid;
            overrun <= overrun | (req_valid & pending & ~grant_mask);
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            user_data_out <= '0;
            out_chan <= '0;
            out_update <= 1'b0;
            busy <= 1'b0;
        end else begin
            out_update <= grant;
            case (state)
                IDLE: if (any_set) begin
                    state <= LOAD;
                    user_data_out <= win_val;
                    out_chan <= winner;
                    rr_ptr <= (winner == CHAN_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    busy <= 1'b1;
                end
                LOAD: begin
                    state <= HOLD;
                    cnt <= '0;
                end
                HOLD: if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loopback_mcnt_arbiter.sv
// tb_loopback_mcnt_arbiter: randomized and directed checks against a behavioural arbiter model.
module tb_loopback_mcnt_arbiter;
    localparam int N = 4;
    localparam int H = 256;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic user_rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [32*N-1:0] req_mcnt = '0;
    logic [31:0] user_data_out;
    logic [CW-1:0] out_chan;
    logic out_update, busy;
    logic [N-1:0] pending, overrun;
    logic [43:0] dut_vec;

    int vec = 0;
    int errs = 0;

    logic [31:0] m_shadow [N];
    logic [N-1:0] m_pend, m_ovr;
    logic [31:0] m_out;
    logic [CW-1:0] m_chan;
    logic m_upd, m_busy;
    int m_rr, m_free;

    loopback_mcnt_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
        .user_clk(clk),
        .user_rst(user_rst),
        .req_valid(req_valid),
        .req_mcnt(req_mcnt),
        .user_data_out(user_data_out),
        .out_chan(out_chan),
        .out_update(out_update),
        .pending(pending),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign dut_vec = {user_data_out, out_chan, out_update, pending, overrun, busy};

    function automatic logic [31:0] tagv(input int w, input logic [31:0] v);
`ifdef LOOPBACK_MCNT_TAG_EN
        return (32'(w) << (32 - CW)) | (v & ((32'd1 << (32 - CW)) - 32'd1));
`else
        return v + 32'(w * 0);
`endif
    endfunction

    function automatic logic [43:0] exp_vec();
        return {m_out, m_chan, m_upd, m_pend, m_ovr, m_busy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_shadow[i] = '0;
        m_pend = '0; m_ovr = '0; m_out = '0; m_chan = '0;
        m_upd = 1'b0; m_busy = 1'b0; m_rr = 0; m_free = 0;
    endtask

    // Model: after a grant the block is unavailable for H+1 edges, then grants at the next edge with work.
    task automatic tick(input logic [N-1:0] v, input logic [32*N-1:0] d);
        int w;
        req_valid = v;
        req_mcnt = d;
        @(posedge clk);
        w = -1;
        if (m_free == 0)
            for (int k = 0; k < N; k++)
                if (w < 0 && m_pend[(m_rr + k) % N]) w = (m_rr + k) % N;
        m_upd = (w >= 0);
        if (w >= 0) begin
            m_out = tagv(w, m_shadow[w]);
            m_chan = CW'(w);
            m_pend[w] = 1'b0;
            m_rr = (w + 1) % N;
            m_free = H + 1;
        end else if (m_free > 0) begin
            m_free--;
        end
        m_busy = (m_free > 0);
        for (int i = 0; i < N; i++)
            if (v[i]) begin
                if (m_pend[i]) m_ovr[i] = 1'b1;
                m_shadow[i] = d[32*i +: 32];
                m_pend[i] = 1'b1;
            end
        @(negedge clk);
        req_valid = '0;
        req_mcnt = '0;
    endtask

    task automatic do_reset();
        user_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        user_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++;
        if (dut_vec !== '0) begin errs++; $display("FAIL reset_values: got %h exp 0", dut_vec); end
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            tick('0, '0);
            vec++;
            if (dut_vec !== exp_vec() || out_update !== 1'b0 || busy !== 1'b0) begin
                errs++; $display("FAIL idle c=%0d: got %h exp %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_single_capture();
        logic [32*N-1:0] d;
        logic [31:0] exp_data;
`ifdef LOOPBACK_MCNT_TAG_EN
        exp_data = 32'h8000_1234;
`else
        exp_data = 32'h0000_1234;
`endif
        do_reset();
        d = '0;
        d[64 +: 32] = 32'h0000_1234;
        tick(4'b0100, d);
        vec++;
        if (pending !== 4'b0100 || out_update !== 1'b0) begin
            errs++; $display("FAIL single_pending: got p=%b u=%b exp p=0100 u=0", pending, out_update);
        end
        tick('0, '0);
        vec++;
        if (out_update !== 1'b1 || user_data_out !== exp_data || out_chan !== 2'd2 || pending !== 4'b0000) begin
            errs++; $display("FAIL single_grant: got u=%b d=%h ch=%0d exp u=1 d=%h ch=2", out_update, user_data_out, out_chan, exp_data);
        end
        for (int c = 0; c < 256; c++) begin
            tick('0, '0);
            vec++;
            if (dut_vec !== exp_vec() || user_data_out !== exp_data || out_update !== 1'b0) begin
                errs++; $display("FAIL single_hold c=%0d: got %h exp %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic run_rr(input logic [31:0] base, input int budget);
        logic [32*N-1:0] d;
        int gt [8];
        int gc [8];
        logic [31:0] gd [8];
        int ng;
        ng = 0;
        for (int i = 0; i < N; i++) d[32*i +: 32] = base + 32'(i);
        tick(4'hF, d);
        for (int c = 0; c < budget; c++) begin
            tick('0, '0);
            vec++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL rr_cycle c=%0d: got %h exp %h", c, dut_vec, exp_vec()); end
            if (out_update === 1'b1 && ng < 8) begin
                gt[ng] = c; gc[ng] = int'(out_chan); gd[ng] = user_data_out; ng++;
            end
        end
        vec++;
        if (ng !== 4) begin errs++; $display("FAIL rr_count: got %0d exp 4", ng); end
        for (int i = 0; i < ng && i < 4; i++) begin
            vec++;
            if (gc[i] !== i || gd[i] !== tagv(i, base + 32'(i))) begin
                errs++; $display("FAIL rr_order %0d: got ch=%0d d=%h exp ch=%0d d=%h", i, gc[i], gd[i], i, tagv(i, base + 32'(i)));
            end
        end
        for (int i = 1; i < ng && i < 4; i++) begin
            vec++;
            if (gt[i] - gt[i-1] !== H + 2) begin errs++; $display("FAIL rr_spacing %0d: got %0d exp %0d", i, gt[i] - gt[i-1], H + 2); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        run_rr(32'h0000_0100, 4 * (H + 2));
        run_rr(32'h0000_0200, 4 * (H + 2) + 20);
    endtask

    task automatic test_overrun();
        logic [32*N-1:0] d;
        bit found;
        do_reset();
        d = '0; d[0 +: 32] = 32'h5;
        tick(4'b0001, d);
        tick('0, '0);
        d = '0; d[32 +: 32] = 32'hA;
        tick(4'b0010, d);
        repeat (3) tick('0, '0);
        d = '0; d[32 +: 32] = 32'hB;
        tick(4'b0010, d);
        vec++;
        if (overrun !== 4'b0010 || pending !== 4'b0010) begin
            errs++; $display("FAIL overrun_flag: got ovr=%b p=%b exp ovr=0010 p=0010", overrun, pending);
        end
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            tick('0, '0);
            vec++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL overrun_cycle c=%0d: got %h exp %h", c, dut_vec, exp_vec()); end
            if (out_update === 1'b1) found = 1;
        end
        vec++;
        if (!found || out_chan !== 2'd1 || user_data_out !== tagv(1, 32'hB) || overrun !== 4'b0010) begin
            errs++; $display("FAIL overrun_grant: got found=%0d ch=%0d d=%h ovr=%b exp ch=1 d=%h ovr=0010", found, out_chan, user_data_out, overrun, tagv(1, 32'hB));
        end
    endtask

    task automatic test_same_cycle();
        logic [32*N-1:0] d;
        bit found;
        do_reset();
        d = '0; d[0 +: 32] = 32'h111;
        tick(4'b0001, d);
        d = '0; d[0 +: 32] = 32'h222;
        tick(4'b0001, d);
        vec++;
        if (out_update !== 1'b1 || user_data_out !== tagv(0, 32'h111) || pending[0] !== 1'b1 || overrun[0] !== 1'b0) begin
            errs++; $display("FAIL same_cycle: got u=%b d=%h p0=%b o0=%b exp u=1 d=%h p0=1 o0=0", out_update, user_data_out, pending[0], overrun[0], tagv(0, 32'h111));
        end
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            tick('0, '0);
            vec++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL same_cycle_run c=%0d: got %h exp %h", c, dut_vec, exp_vec()); end
            if (out_update === 1'b1) found = 1;
        end
        vec++;
        if (!found || out_chan !== 2'd0 || user_data_out !== tagv(0, 32'h222)) begin
            errs++; $display("FAIL same_cycle_next: got found=%0d ch=%0d d=%h exp ch=0 d=%h", found, out_chan, user_data_out, tagv(0, 32'h222));
        end
    endtask

    task automatic test_async_reset();
        logic [32*N-1:0] d;
        do_reset();
        d = '0; d[96 +: 32] = 32'hDEAD;
        tick(4'b1000, d);
        repeat (12) tick('0, '0);
        vec++;
        if (busy !== 1'b1 || user_data_out !== tagv(3, 32'hDEAD)) begin
            errs++; $display("FAIL areset_pre: got busy=%b d=%h exp busy=1 d=%h", busy, user_data_out, tagv(3, 32'hDEAD));
        end
        #2 user_rst = 1'b1;
        #1;
        vec++;
        if (dut_vec !== '0) begin errs++; $display("FAIL areset_immediate: got %h exp 0", dut_vec); end
        model_reset();
        @(negedge clk);
        user_rst = 1'b0;
        d = '0; d[32 +: 32] = 32'h77;
        tick(4'b0010, d);
        vec++;
        if (dut_vec !== exp_vec() || pending !== 4'b0010 || out_update !== 1'b0) begin
            errs++; $display("FAIL areset_capture: got %h exp %h", dut_vec, exp_vec());
        end
        tick('0, '0);
        vec++;
        if (out_update !== 1'b1 || out_chan !== 2'd1 || user_data_out !== tagv(1, 32'h77)) begin
            errs++; $display("FAIL areset_latency: got u=%b ch=%0d d=%h exp u=1 ch=1 d=%h", out_update, out_chan, user_data_out, tagv(1, 32'h77));
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [32*N-1:0] d;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 99) < 3);
                d[32*i +: 32] = $urandom;
            end
            tick(v, d);
            vec++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL random c=%0d: got %h exp %h", c, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_capture();
        test_round_robin();
        test_overrun();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
